// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand-fetch stage: register address, data word and the
// bundles that travel from decode into the stage and from the stage to execute.
package operand_fetch_pkg;

   typedef logic [4:0]  creg_addr_t;
   typedef logic [63:0] u64;

   localparam int SB_CNT_W     = 2;
   localparam int OF_PAYLOAD_W = 64;
   localparam int NUM_CREGS    = 32;

   typedef struct packed {
      creg_addr_t              rs1;
      creg_addr_t              rs2;
      creg_addr_t              rd;
      logic                    rd_wen;
      logic [OF_PAYLOAD_W-1:0] payload;
   } of_in_t;

   typedef struct packed {
      u64                      rs1_val;
      u64                      rs2_val;
      creg_addr_t              rd;
      logic                    rd_wen;
      logic [OF_PAYLOAD_W-1:0] payload;
   } of_out_t;

   // x0 reads as zero; a same-cycle writeback wins over the stale regfile value.
   function automatic u64 select_operand(input creg_addr_t rs,
                                         input logic       wb_valid,
                                         input creg_addr_t wb_addr,
                                         input u64         wb_data,
                                         input u64         rf_data);
      if (rs == '0) begin
         return '0;
      end
      if (wb_valid && (wb_addr == rs)) begin
         return wb_data;
      end
      return rf_data;
   endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Per-register count of writes that have left for execute but not yet written back.
// x0 is never tracked; counters neither wrap past max nor drop below zero.
module operand_fetch_scoreboard #(
   parameter int CNT_W = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc_valid,
   input  logic [4:0] inc_addr,
   input  logic       dec_valid,
   input  logic [4:0] dec_addr,
   input  logic [4:0] lk1_addr,
   input  logic [4:0] lk2_addr,
   input  logic [4:0] lk3_addr,
   output logic       lk1_pend,
   output logic       lk1_one,
   output logic       lk2_pend,
   output logic       lk2_one,
   output logic       lk3_full
);
   import operand_fetch_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0]     cnt     [NUM_CREGS];
   logic [CNT_W-1:0]     cnt_nxt [NUM_CREGS];
   logic [NUM_CREGS-1:0] inc_sel;
   logic [NUM_CREGS-1:0] dec_sel;

   always_comb begin
      inc_sel = '0;
      dec_sel = '0;
      if (inc_valid && (inc_addr != '0)) begin
         inc_sel[inc_addr] = 1'b1;
      end
      if (dec_valid && (dec_addr != '0)) begin
         dec_sel[dec_addr] = 1'b1;
      end
   end

   // An exit and a writeback to the same register in one cycle cancel out.
   always_comb begin
      for (int i = 0; i < NUM_CREGS; i++) begin
         cnt_nxt[i] = cnt[i];
         if (inc_sel[i] && !dec_sel[i] && (cnt[i] != CNT_MAX)) begin
            cnt_nxt[i] = cnt[i] + CNT_ONE;
         end else if (dec_sel[i] && !inc_sel[i] && (cnt[i] != '0)) begin
            cnt_nxt[i] = cnt[i] - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CREGS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CREGS; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

   assign lk1_pend = (cnt[lk1_addr] != '0);
   assign lk1_one  = (cnt[lk1_addr] == CNT_ONE);
   assign lk2_pend = (cnt[lk2_addr] != '0);
   assign lk2_one  = (cnt[lk2_addr] == CNT_ONE);
   assign lk3_full = (cnt[lk3_addr] == CNT_MAX);

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: reads sources, forwards same-cycle writeback, stalls on RAW
// hazards tracked by a pending-write scoreboard, and registers operands for execute.
module operand_fetch #(
   parameter int PAYLOAD_W = 64,
   parameter int SB_CNT_W  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic [4:0]           in_rd,
   input  logic                 in_rd_wen,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic [4:0]           ra1,
   output logic [4:0]           ra2,
   input  logic [63:0]          rd1,
   input  logic [63:0]          rd2,
   input  logic                 wb_valid,
   input  logic [4:0]           wb_addr,
   input  logic [63:0]          wb_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [63:0]          out_rs1_val,
   output logic [63:0]          out_rs2_val,
   output logic [4:0]           out_rd,
   output logic                 out_rd_wen,
   output logic [PAYLOAD_W-1:0] out_payload
);
   import operand_fetch_pkg::*;

   of_in_t  in_bus;
   of_out_t out_q;
   of_out_t out_d;
   logic    out_valid_q;

   logic sb1_pend, sb1_one, sb2_pend, sb2_one, sb_rd_full;
   logic held1, held2, wb_hit1, wb_hit2;
   logic rs1_blocked, rs2_blocked, rd_full_stall, hazard;
   logic accept, exit_xfer;

   assign in_bus = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, rd_wen: in_rd_wen,
                     payload: in_payload};

   assign ra1 = in_bus.rs1;
   assign ra2 = in_bus.rs2;

   // The held instruction has not been counted yet, so it is checked separately.
   assign held1   = out_valid_q && out_q.rd_wen && (out_q.rd == in_bus.rs1);
   assign held2   = out_valid_q && out_q.rd_wen && (out_q.rd == in_bus.rs2);
   assign wb_hit1 = wb_valid && (wb_addr == in_bus.rs1);
   assign wb_hit2 = wb_valid && (wb_addr == in_bus.rs2);

   assign rs1_blocked = (in_bus.rs1 != '0) && (sb1_pend || held1) &&
                        !(sb1_one && wb_hit1 && !held1);
   assign rs2_blocked = (in_bus.rs2 != '0) && (sb2_pend || held2) &&
                        !(sb2_one && wb_hit2 && !held2);
   assign rd_full_stall = in_bus.rd_wen && (in_bus.rd != '0) && sb_rd_full;

   assign hazard    = rs1_blocked || rs2_blocked || rd_full_stall;
   assign in_ready  = !hazard && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign exit_xfer = out_valid_q && out_ready;

   always_comb begin
      out_d         = '0;
      out_d.rs1_val = select_operand(in_bus.rs1, wb_valid, wb_addr, wb_data, rd1);
      out_d.rs2_val = select_operand(in_bus.rs2, wb_valid, wb_addr, wb_data, rd2);
      out_d.rd      = in_bus.rd;
      out_d.rd_wen  = in_bus.rd_wen;
      out_d.payload = in_bus.payload;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_q       <= out_d;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // Writes are counted when they leave for execute, not when they are accepted here.
   operand_fetch_scoreboard #(
      .CNT_W (SB_CNT_W)
   ) u_sb (
      .clk       (clk),
      .reset     (reset),
      .inc_valid (exit_xfer && out_q.rd_wen),
      .inc_addr  (out_q.rd),
      .dec_valid (wb_valid),
      .dec_addr  (wb_addr),
      .lk1_addr  (in_bus.rs1),
      .lk2_addr  (in_bus.rs2),
      .lk3_addr  (in_bus.rd),
      .lk1_pend  (sb1_pend),
      .lk1_one   (sb1_one),
      .lk2_pend  (sb2_pend),
      .lk2_one   (sb2_one),
      .lk3_full  (sb_rd_full)
   );

   assign out_valid   = out_valid_q;
   assign out_rs1_val = out_q.rs1_val;
   assign out_rs2_val = out_q.rs2_val;
   assign out_rd      = out_q.rd;
   assign out_rd_wen  = out_q.rd_wen;
   assign out_payload = out_q.payload;

endmodule
